// File: rtl/lfsr_chain_pkg.sv
// Shared sizing constants for the XNOR-feedback shift chain.
`timescale 1ns/1ps
package lfsr_chain_pkg;

  localparam int unsigned SEG_LEN_DEF = 10;
  localparam int unsigned TAP_DEF     = 7;
  localparam int unsigned N_SEG_DEF   = 16000;

endpackage

// File: rtl/lfsr_shift_chain_if.sv
// Serial data-in / data-out pair of the shift chain.
`timescale 1ns/1ps
interface lfsr_shift_chain_if;

  logic d;
  logic q;

  modport master (output d, input  q);
  modport slave  (input  d, output q);

endinterface

// File: rtl/lfsr_shift_seg.sv
// One chain segment: an XNOR of the input and flop TAP, feeding a SEG_LEN-deep clearable shift line.
`timescale 1ns/1ps
module lfsr_shift_seg
  import lfsr_chain_pkg::*;
#(
  parameter int unsigned SEG_LEN = SEG_LEN_DEF,
  parameter int unsigned TAP     = TAP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // r_s[1] is the flop fed by the XNOR, r_s[SEG_LEN] drives the segment output.
  logic [SEG_LEN:1] r_s;
  logic             w_fb;

  assign w_fb = ~(d ^ r_s[TAP]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s <= '0;
    end else begin
      r_s <= {r_s[SEG_LEN-1:1], w_fb};
    end
  end

  assign q = r_s[SEG_LEN];

endmodule

// File: rtl/lfsr_shift_chain.sv
// N_SEG cascaded XNOR-feedback segments; d enters segment 0, the last segment drives q.
`timescale 1ns/1ps
module lfsr_shift_chain
  import lfsr_chain_pkg::*;
#(
  parameter int unsigned N_SEG   = N_SEG_DEF,
  parameter int unsigned SEG_LEN = SEG_LEN_DEF,
  parameter int unsigned TAP     = TAP_DEF
) (
  input logic               clk,
  input logic               reset,
  lfsr_shift_chain_if.slave bus
);

  // w_link[k] is the input of segment k; w_link[N_SEG] is the chain output.
  logic [N_SEG:0] w_link;

  assign w_link[0] = bus.d;

  for (genvar k = 0; k < N_SEG; k++) begin : g_seg
    lfsr_shift_seg #(
      .SEG_LEN (SEG_LEN),
      .TAP     (TAP)
    ) u_seg (
      .clk   (clk),
      .reset (reset),
      .d     (w_link[k]),
      .q     (w_link[k+1])
    );
  end

  assign bus.q = w_link[N_SEG];

endmodule

// File: tb/tb_lfsr_shift_chain.sv
// Bench: one- and two-segment chains with driven d, plus the default chain closed q->d.
`timescale 1ns/1ps
module tb_lfsr_shift_chain;
  import lfsr_chain_pkg::*;

  localparam int L  = int'(SEG_LEN_DEF);
  localparam int T  = int'(TAP_DEF);
  localparam int NB = int'(N_SEG_DEF);

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  int   n_pass   = 0;
  int   n_checks = 0;

  always #50 clk = ~clk;

  lfsr_shift_chain_if if_a ();
  lfsr_shift_chain_if if_b ();
  lfsr_shift_chain_if if_c ();

  assign if_c.d = if_c.q;

  lfsr_shift_chain #(.N_SEG(1), .SEG_LEN(SEG_LEN_DEF), .TAP(TAP_DEF)) u_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );
  lfsr_shift_chain #(.N_SEG(2), .SEG_LEN(SEG_LEN_DEF), .TAP(TAP_DEF)) u_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );
  lfsr_shift_chain #(.N_SEG(N_SEG_DEF), .SEG_LEN(SEG_LEN_DEF), .TAP(TAP_DEF)) u_c (
    .clk   (clk),
    .reset (rst_c),
    .bus   (if_c)
  );

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask

  // Reference model as first-flop histories: x_k[n] is segment k's first flop after edge n,
  // flop i holds x_k[n-i+1], and x_k[n] = ~(in_k[n-1] ^ x_k[n-TAP]).
  bit [1:0] sx [0:2047];
  int       sn;

  function automatic bit [1:0] sx_at(input int n);
    return (n < 1) ? 2'b00 : sx[n];
  endfunction

  task automatic small_step(input bit din);
    bit [1:0] prev, tap, inv;
    sn++;
    prev = sx_at(sn - L);
    tap  = sx_at(sn - T);
    inv  = {prev[0], din};
    sx[sn] = ~(inv ^ tap);
  endtask

  bit [NB-1:0] bx [0:15];
  int          bn;

  function automatic bit [NB-1:0] bx_at(input int n);
    return (n < 1) ? '0 : bx[n % 16];
  endfunction

  // Closed loop: segment 0 is fed by the last segment, so the input vector is a rotation.
  task automatic big_step();
    bit [NB-1:0] prev, tap;
    bn++;
    prev = bx_at(bn - L);
    tap  = bx_at(bn - T);
    bx[bn % 16] = ~({prev[NB-2:0], prev[NB-1]} ^ tap);
  endtask

  // mode 0: d=0, 1: d=1, 2: random d. Edge counts restart at each call, after a release.
  task automatic run_small(input int nseg, input int nedges, input int mode, input string nm);
    bit [1:0]   xq;
    bit [L-1:0] st;
    bit         din;
    bit         exp_pat;
    for (int e = 1; e <= nedges; e++) begin
      din = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      if (nseg == 1) if_a.d = din;
      else           if_b.d = din;
      @(posedge clk);
      #1;
      small_step(din);
      xq = sx_at(sn - L + 1);
      if (nseg == 1) begin
        for (int i = 1; i <= L; i++) begin
          bit [1:0] xi;
          xi = sx_at(sn - i + 1);
          st[i-1] = xi[0];
        end
        check_val($sformatf("%s_q_e%0d", nm, e), 16'(if_a.q), 16'(xq[0]));
        check_val($sformatf("%s_state_e%0d", nm, e), 16'(u_a.g_seg[0].u_seg.r_s), 16'(st));
        if (mode == 0) begin
          exp_pat = (e >= L) && ((((e - L) / T) % 2) == 0);
          check_val($sformatf("%s_pat_e%0d", nm, e), 16'(if_a.q), 16'(exp_pat));
        end
        if (mode == 1) check_val($sformatf("%s_hold_e%0d", nm, e), 16'(if_a.q), 16'h0);
      end else begin
        check_val($sformatf("%s_seg0_e%0d", nm, e), 16'(u_b.g_seg[0].u_seg.q), 16'(xq[0]));
        check_val($sformatf("%s_q_e%0d", nm, e), 16'(if_b.q), 16'(xq[1]));
      end
    end
  endtask

  task automatic reset_a(input string nm);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check_val({nm, "_q_async"}, 16'(if_a.q), 16'h0);
    check_val({nm, "_state_async"}, 16'(u_a.g_seg[0].u_seg.r_s), 16'h0);
  endtask

  task automatic release_a();
    @(negedge clk);
    rst_a = 1'b1;
    sn = 0;
  endtask

  initial begin
    bit [NB-1:0] xb;
    if_a.d = 1'b0;
    if_b.d = 1'b0;
    bn = 0;
    sn = 0;

    // Closed-loop default chain: reset low for the first 25 ns, then 1000 edges.
    #10;
    check_val("c_reset_q", 16'(if_c.q), 16'h0);
    #15;
    rst_c = 1'b1;
    for (int e = 1; e <= 1000; e++) begin
      @(posedge clk);
      #1;
      big_step();
      xb = bx_at(bn - L + 1);
      check_val($sformatf("c_q_e%0d", e), 16'(if_c.q), 16'(xb[NB-1]));
      check_val($sformatf("c_noX_e%0d", e), 16'($isunknown(if_c.q)), 16'h0);
    end
    #20;
    rst_c = 1'b0;
    #1;
    check_val("c_q_async_clear", 16'(if_c.q), 16'h0);

    // Single segment: reset held through many clock edges leaves everything clear.
    check_val("a_reset_q", 16'(if_a.q), 16'h0);
    check_val("a_reset_state", 16'(u_a.g_seg[0].u_seg.r_s), 16'h0);
    if_a.d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("a_reset_edges_q", 16'(if_a.q), 16'h0);
    check_val("a_reset_edges_state", 16'(u_a.g_seg[0].u_seg.r_s), 16'h0);

    release_a();
    run_small(1, 30, 0, "a_toggle");

    // Mid-run reset between edges 12 and 13, then the pattern restarts.
    reset_a("a_pre_mid");
    release_a();
    run_small(1, 12, 0, "a_mid_pre");
    #20;
    rst_a = 1'b0;
    #1;
    check_val("a_mid_q_async", 16'(if_a.q), 16'h0);
    check_val("a_mid_state_async", 16'(u_a.g_seg[0].u_seg.r_s), 16'h0);
    release_a();
    run_small(1, 16, 0, "a_mid_post");

    reset_a("a_pre_hold");
    release_a();
    run_small(1, 100, 1, "a_hold1");

    reset_a("a_pre_rand");
    release_a();
    run_small(1, 200, 2, "a_rand");

    // Two segments: constant zero input, then random input.
    check_val("b_reset_q", 16'(if_b.q), 16'h0);
    @(negedge clk);
    rst_b = 1'b1;
    sn = 0;
    run_small(2, 40, 0, "b_zero");
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check_val("b_q_async_clear", 16'(if_b.q), 16'h0);
    @(negedge clk);
    rst_b = 1'b1;
    sn = 0;
    run_small(2, 200, 2, "b_rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
